// File: rtl/fu_alu_pipe.sv
// rtl/fu_alu_pipe.sv - pipelined integer ALU / branch-condition functional unit
//
// Ports:
//   clock, reset (async, active-low), flush (synchronous squash of all in-flight ops)
//   issue side   : in_valid/in_ready, in_opa, in_opb, in_func, in_rs1, in_rs2,
//                  in_br_func, in_cond_branch, in_uncond_branch, in_tag
//   complete side: out_valid/out_ready, out_result, out_take_branch, out_tag
//   occupancy    : number of valid pipeline stages
//
// in_func encoding (4 bits):
//   0 ADD  1 SUB  2 AND  3 OR  4 XOR  5 SLT  6 SLTU  7 SLL  8 SRL  9 SRA
//   10 MUL 11 MULH 12 MULHSU 13 MULHU  14..15 -> result 32'hfacebeec
//
// The result is computed combinationally at issue and then simply carried
// down a LATENCY-deep register chain. Every stage holds while the last stage
// has a result the consumer is not taking (global stall).

module fu_alu_pipe #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 6,
    localparam int OCC_W  = $clog2(LATENCY + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_opa,
    input  logic [XLEN-1:0]  in_opb,
    input  logic [3:0]       in_func,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [2:0]       in_br_func,
    input  logic             in_cond_branch,
    input  logic             in_uncond_branch,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_take_branch,
    output logic [TAG_W-1:0] out_tag,
    output logic [OCC_W-1:0] occupancy
);

    localparam logic [3:0] FN_ADD    = 4'd0;
    localparam logic [3:0] FN_SUB    = 4'd1;
    localparam logic [3:0] FN_AND    = 4'd2;
    localparam logic [3:0] FN_OR     = 4'd3;
    localparam logic [3:0] FN_XOR    = 4'd4;
    localparam logic [3:0] FN_SLT    = 4'd5;
    localparam logic [3:0] FN_SLTU   = 4'd6;
    localparam logic [3:0] FN_SLL    = 4'd7;
    localparam logic [3:0] FN_SRL    = 4'd8;
    localparam logic [3:0] FN_SRA    = 4'd9;
    localparam logic [3:0] FN_MUL    = 4'd10;
    localparam logic [3:0] FN_MULH   = 4'd11;
    localparam logic [3:0] FN_MULHSU = 4'd12;
    localparam logic [3:0] FN_MULHU  = 4'd13;

    // ------------------------------------------------------------------
    // Combinational compute on the issue-side inputs
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   alu_res;
    logic              cond;
    logic              take;
    logic [4:0]        shamt;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_p;

    assign shamt = in_opb[4:0];

    // One shared 2*XLEN multiplier; the operand extension selects the
    // signedness, so MUL/MULHU use zero-extension and MULH/MULHSU sign-extend.
    always_comb begin
        mul_a = {{XLEN{1'b0}}, in_opa};
        mul_b = {{XLEN{1'b0}}, in_opb};
        if (in_func == FN_MULH || in_func == FN_MULHSU) begin
            mul_a = {{XLEN{in_opa[XLEN-1]}}, in_opa};
        end
        if (in_func == FN_MULH) begin
            mul_b = {{XLEN{in_opb[XLEN-1]}}, in_opb};
        end
    end

    assign mul_p = mul_a * mul_b;

    always_comb begin
        alu_res = XLEN'(32'hfacebeec);
        case (in_func)
            FN_ADD:    alu_res = in_opa + in_opb;
            FN_SUB:    alu_res = in_opa - in_opb;
            FN_AND:    alu_res = in_opa & in_opb;
            FN_OR:     alu_res = in_opa | in_opb;
            FN_XOR:    alu_res = in_opa ^ in_opb;
            FN_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(in_opa) < $signed(in_opb))};
            FN_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (in_opa < in_opb)};
            FN_SLL:    alu_res = in_opa << shamt;
            FN_SRL:    alu_res = in_opa >> shamt;
            FN_SRA:    alu_res = $signed(in_opa) >>> shamt;
            FN_MUL:    alu_res = mul_p[XLEN-1:0];
            FN_MULH,
            FN_MULHSU,
            FN_MULHU:  alu_res = mul_p[2*XLEN-1:XLEN];
            default:   alu_res = XLEN'(32'hfacebeec);
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (in_br_func)
            3'b000:  cond = (in_rs1 == in_rs2);
            3'b001:  cond = (in_rs1 != in_rs2);
            3'b100:  cond = ($signed(in_rs1) <  $signed(in_rs2));
            3'b101:  cond = ($signed(in_rs1) >= $signed(in_rs2));
            3'b110:  cond = (in_rs1 <  in_rs2);
            3'b111:  cond = (in_rs1 >= in_rs2);
            default: cond = 1'b0;
        endcase
        take = in_uncond_branch | (in_cond_branch & cond);
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [LATENCY-1:0] take_q;
    logic [XLEN-1:0]    res_q [LATENCY];
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;
    logic               stall;
    logic               accept;

    assign stall  = vld_q[LATENCY-1] & ~out_ready;
    assign accept = in_valid & ~stall & ~flush;

    // Valid bits depend only on in_valid, never on data inputs.
    always_comb begin
        vld_d = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (!stall) begin
            vld_d[0] = accept;
            for (int k = 1; k < LATENCY; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    // Occupancy is kept in its own register so the output is a clean flop.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < LATENCY; k++) begin
            occ_d = occ_d + OCC_W'(vld_d[k]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q  <= '0;
            occ_q  <= '0;
            take_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
            if (!stall) begin
                // Bubbles shift like ops; stage 0 data only changes on accept.
                for (int k = 1; k < LATENCY; k++) begin
                    res_q[k]  <= res_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                    take_q[k] <= take_q[k-1];
                end
                if (accept) begin
                    res_q[0]  <= alu_res;
                    tag_q[0]  <= in_tag;
                    take_q[0] <= take;
                end
            end
        end
    end

    // out_valid is masked during flush so no transfer can happen that cycle.
    assign out_valid       = vld_q[LATENCY-1] & ~flush;
    assign out_result      = res_q[LATENCY-1];
    assign out_take_branch = take_q[LATENCY-1];
    assign out_tag         = tag_q[LATENCY-1];
    assign occupancy       = occ_q;
    assign in_ready        = ~stall;

endmodule

// File: tb/tb_fu_alu_pipe.sv
// tb/tb_fu_alu_pipe.sv - scoreboard bench for fu_alu_pipe at LATENCY 2, 1 and 4
module tb_fu_alu_pipe;

    localparam int NI = 3;

    typedef struct {
        logic [31:0] res;
        logic        take;
        logic [5:0]  tag;
        int          acc;
        int          nr;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_opa, in_opb, in_rs1, in_rs2;
    logic [3:0]  in_func;
    logic [2:0]  in_br_func;
    logic        in_cond_branch, in_uncond_branch;
    logic [5:0]  in_tag;
    logic        out_ready;

    logic [NI-1:0]        in_ready_a;
    logic [NI-1:0]        out_valid_a;
    logic [NI-1:0]        take_a;
    logic [NI-1:0][31:0]  result_a;
    logic [NI-1:0][5:0]   tag_a;
    logic [NI-1:0][3:0]   occ_a;

    logic        dir_en;
    logic [31:0] dir_res;
    logic        dir_take;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   nrdy    = 0;
    exp_t sbq [NI][$];

    function automatic int lat_of(int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L  = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        localparam int OW = $clog2(L + 1);
        logic [OW-1:0] occ;
        fu_alu_pipe #(.XLEN(32), .LATENCY(L), .TAG_W(6)) u_dut (
            .clock            (clock),
            .reset            (reset),
            .flush            (flush),
            .in_valid         (in_valid),
            .in_ready         (in_ready_a[g]),
            .in_opa           (in_opa),
            .in_opb           (in_opb),
            .in_func          (in_func),
            .in_rs1           (in_rs1),
            .in_rs2           (in_rs2),
            .in_br_func       (in_br_func),
            .in_cond_branch   (in_cond_branch),
            .in_uncond_branch (in_uncond_branch),
            .in_tag           (in_tag),
            .out_valid        (out_valid_a[g]),
            .out_ready        (out_ready),
            .out_result       (result_a[g]),
            .out_take_branch  (take_a[g]),
            .out_tag          (tag_a[g]),
            .occupancy        (occ)
        );
        assign occ_a[g] = 4'(occ);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d (lat %0d): got %h, expected %h", nm, g, lat_of(g), act, exp);
    endfunction

    // Reference model: arithmetic straight from the op definitions.
    function automatic logic [31:0] ref_alu(logic [3:0] f, logic [31:0] a, logic [31:0] b);
        longint      sa  = longint'($signed(a));
        longint      sb  = longint'($signed(b));
        longint      ub  = longint'({32'b0, b});
        logic [63:0] pu  = {32'b0, a} * {32'b0, b};
        logic [63:0] pss = 64'(sa * sb);
        logic [63:0] psu = 64'(sa * ub);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return 32'(sa >>> b[4:0]);
            4'd10:   return pu[31:0];
            4'd11:   return pss[63:32];
            4'd12:   return psu[63:32];
            4'd13:   return pu[63:32];
            default: return 32'hfacebeec;
        endcase
    endfunction

    function automatic logic ref_take(logic [2:0] bf, logic [31:0] r1, logic [31:0] r2,
                                      logic c, logic u);
        logic t;
        case (bf)
            3'b000:  t = (r1 == r2);
            3'b001:  t = (r1 != r2);
            3'b100:  t = ($signed(r1) <  $signed(r2));
            3'b101:  t = ($signed(r1) >= $signed(r2));
            3'b110:  t = (r1 <  r2);
            3'b111:  t = (r1 >= r2);
            default: t = 1'b0;
        endcase
        return u | (c & t);
    endfunction

    // Monitor / scoreboard: every falling edge, per instance.
    initial begin
        exp_t e;
        int   lat;
        int   slack;
        forever begin
            @(negedge clock);
            if (!out_ready) nrdy++;
            for (int g = 0; g < NI; g++) begin
                if (!reset) begin
                    sbq[g].delete();
                    continue;
                end
                chk("occupancy", g, 32'(occ_a[g]), sbq[g].size());
                if (sbq[g].size() == 0) chk("spurious_out_valid", g, 32'(out_valid_a[g]), 0);
                else if (flush) chk("flush_gates_out_valid", g, 32'(out_valid_a[g]), 0);
                if (out_valid_a[g] && out_ready && sbq[g].size() > 0) begin
                    e = sbq[g].pop_front();
                    chk("result", g, result_a[g], e.res);
                    chk("take_branch", g, 32'(take_a[g]), 32'(e.take));
                    chk("tag", g, 32'(tag_a[g]), 32'(e.tag));
                    lat   = cyc - e.acc;
                    slack = nrdy - e.nr;
                    n_total++;
                    if (lat >= lat_of(g) && lat <= lat_of(g) + slack) n_pass++;
                    else $display("FAIL latency inst%0d: %0d cycles, required %0d..%0d",
                                  g, lat, lat_of(g), lat_of(g) + slack);
                end else if (sbq[g].size() > 0 && !flush) begin
                    e = sbq[g][0];
                    if (cyc - e.acc >= lat_of(g) + (nrdy - e.nr))
                        chk("late_out_valid", g, 32'(out_valid_a[g]), 1);
                end
                if (flush) begin
                    sbq[g].delete();
                end else if (in_valid && in_ready_a[g]) begin
                    e.res  = dir_en ? dir_res : ref_alu(in_func, in_opa, in_opb);
                    e.take = dir_en ? dir_take
                                    : ref_take(in_br_func, in_rs1, in_rs2, in_cond_branch, in_uncond_branch);
                    e.tag  = in_tag;
                    e.acc  = cyc;
                    e.nr   = nrdy;
                    sbq[g].push_back(e);
                end
            end
        end
    end

    task automatic set_op(logic [3:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] r1,
                          logic [31:0] r2, logic [2:0] bf, logic c, logic u, logic [5:0] t);
        in_func = f; in_opa = a; in_opb = b; in_rs1 = r1; in_rs2 = r2;
        in_br_func = bf; in_cond_branch = c; in_uncond_branch = u; in_tag = t;
    endtask

    task automatic rand_op();
        logic [31:0] a, r1;
        a  = $urandom;
        r1 = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 3);
        set_op(4'($urandom_range(0, 15)), a,
               ($urandom_range(0, 3) == 0) ? a : $urandom,
               r1, ($urandom_range(0, 2) == 0) ? r1 : $urandom_range(0, 3) - 1,
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 4) == 0), 6'($urandom));
        dir_en = 1'b0;
    endtask

    // Directed issue with literal expectations; waits (bounded) for main instance.
    task automatic issue(logic [3:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] r1,
                         logic [31:0] r2, logic [2:0] bf, logic c, logic u, logic [5:0] t,
                         logic [31:0] xres, logic xtake);
        int n = 0;
        set_op(f, a, b, r1, r2, bf, c, u, t);
        dir_en = 1'b1; dir_res = xres; dir_take = xtake;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready_a[0] && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) chk("issue_timeout", 0, 32'(in_ready_a[0]), 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        dir_en   = 1'b0;
    endtask

    task automatic check_reset_state(string nm);
        for (int g = 0; g < NI; g++) begin
            chk({nm, "_out_valid"}, g, 32'(out_valid_a[g]), 0);
            chk({nm, "_out_result"}, g, result_a[g], 0);
            chk({nm, "_out_take"}, g, 32'(take_a[g]), 0);
            chk({nm, "_out_tag"}, g, 32'(tag_a[g]), 0);
            chk({nm, "_occupancy"}, g, 32'(occ_a[g]), 0);
            chk({nm, "_in_ready"}, g, 32'(in_ready_a[g]), 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) > 0 && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        for (int g = 0; g < NI; g++) chk("drain_empty", g, sbq[g].size(), 0);
    endtask

    // Fill the LATENCY=2 instance with out_ready low until it stalls.
    task automatic fill_main();
        int n = 0;
        out_ready = 1'b0;
        rand_op();
        in_valid = 1'b1;
        @(negedge clock);
        while (in_ready_a[0] && n < 10) begin
            @(posedge clock); #1;
            rand_op();
            @(negedge clock);
            n++;
        end
        chk("fill_stalls", 0, 32'(in_ready_a[0]), 0);
    endtask

    initial begin
        logic [31:0] r0;
        logic [5:0]  t0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        dir_en = 1'b0; dir_res = '0; dir_take = 1'b0;
        set_op(4'd0, 0, 0, 0, 0, 3'd0, 1'b0, 1'b0, 6'd0);
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("reset");
        reset = 1'b1;

        // Directed ALU / branch cases, back to back.
        issue(4'd0,  32'd5, 32'd7, 0, 0, 3'b000, 1'b0, 1'b0, 6'd3, 32'd12, 1'b0);
        issue(4'd11, 32'h80000000, 32'h80000000, 0, 0, 3'b000, 1'b0, 1'b0, 6'd4, 32'h40000000, 1'b0);
        issue(4'd13, 32'hffffffff, 32'hffffffff, 0, 0, 3'b000, 1'b0, 1'b0, 6'd5, 32'hfffffffe, 1'b0);
        issue(4'd9,  32'h80000000, 32'd31, 0, 0, 3'b000, 1'b0, 1'b0, 6'd6, 32'hffffffff, 1'b0);
        issue(4'd15, 32'd1, 32'd2, 0, 0, 3'b000, 1'b0, 1'b0, 6'd7, 32'hfacebeec, 1'b0);
        issue(4'd12, 32'hffffffff, 32'd2, 0, 0, 3'b000, 1'b0, 1'b0, 6'd8, 32'hffffffff, 1'b0);
        issue(4'd5,  32'hffffffff, 32'd1, 0, 0, 3'b000, 1'b0, 1'b0, 6'd9, 32'd1, 1'b0);
        issue(4'd1,  32'd3, 32'd5, 0, 0, 3'b000, 1'b0, 1'b0, 6'd10, 32'hfffffffe, 1'b0);
        issue(4'd0,  0, 0, 32'hffffffff, 32'd1, 3'b100, 1'b1, 1'b0, 6'd11, 32'd0, 1'b1);
        issue(4'd0,  0, 0, 32'hffffffff, 32'd1, 3'b110, 1'b1, 1'b0, 6'd12, 32'd0, 1'b0);
        issue(4'd0,  0, 0, 32'd1, 32'd2, 3'b000, 1'b0, 1'b1, 6'd13, 32'd0, 1'b1);
        issue(4'd0,  0, 0, 32'd9, 32'd9, 3'b000, 1'b1, 1'b0, 6'd14, 32'd0, 1'b1);
        issue(4'd0,  0, 0, 32'd9, 32'd9, 3'b010, 1'b1, 1'b0, 6'd15, 32'd0, 1'b0);
        drain();

        // Backpressure: hold output for 4 cycles, then release.
        fill_main();
        r0 = result_a[0];
        t0 = tag_a[0];
        repeat (4) begin
            @(posedge clock); #1;
            rand_op();
            @(negedge clock);
            chk("stall_in_ready", 0, 32'(in_ready_a[0]), 0);
            chk("stall_occupancy", 0, 32'(occ_a[0]), 2);
            chk("stall_out_valid", 0, 32'(out_valid_a[0]), 1);
            chk("stall_result_held", 0, result_a[0], r0);
            chk("stall_tag_held", 0, 32'(tag_a[0]), 32'(t0));
        end
        @(posedge clock); #1;
        drain();

        // Flush with a full pipeline and a same-cycle issue.
        fill_main();
        @(posedge clock); #1;
        rand_op();
        in_tag   = 6'h3f;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clock);
        for (int g = 0; g < NI; g++) chk("flush_out_valid", g, 32'(out_valid_a[g]), 0);
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int g = 0; g < NI; g++) chk("flush_occupancy", g, 32'(occ_a[g]), 0);
        out_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;

        // Randomised traffic with backpressure and occasional flush.
        for (int i = 0; i < 1500; i++) begin
            rand_op();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 8);
            flush     = ($urandom_range(0, 49) == 0);
            @(posedge clock); #1;
        end
        flush = 1'b0;
        drain();

        // Asynchronous reset mid-stream, then first-edge accept.
        for (int i = 0; i < 20; i++) begin
            rand_op();
            in_valid  = 1'b1;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock); #1;
        end
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("async_reset");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        issue(4'd0, 32'd1, 32'd1, 0, 0, 3'b000, 1'b0, 1'b0, 6'd21, 32'd2, 1'b0);
        for (int g = 0; g < NI; g++) chk("first_edge_accept", g, 32'(occ_a[g]), 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fu_alu_pipe.md
Name: fu_alu_pipe

Overview:
- Parametrised successor to the single-cycle ALU functional unit: integer ALU plus branch-condition evaluation behind a LATENCY-deep pipeline.
- Full valid/ready handshake on both sides, global backpressure stall, and flush for mispredict recovery.
- Sits between the RS issue port and the CDB/complete arbiter. Carries an opaque tag (ROB/PRF index) alongside each result.

Parameters:
- XLEN, 32, operand/result width.
- LATENCY, 2, cycles from accept to out_valid with no stall. Legal range 1..8.
- TAG_W, 6, width of the pass-through tag.
- OCC_W, $clog2(LATENCY+1), occupancy counter width (derived; do not override).

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  reset, asynchronous, active-low. Asserted low clears all state.
- flush  in  1  synchronous squash of every in-flight op.
- in_valid  in  1  issue request.
- in_ready  out  1  unit can accept this cycle.
- in_opa  in  XLEN  operand A (already muxed).
- in_opb  in  XLEN  operand B (already muxed).
- in_func  in  ALU_FUNC  op select, shared enum.
- in_rs1  in  XLEN  branch compare value 1.
- in_rs2  in  XLEN  branch compare value 2.
- in_br_func  in  3  branch funct3.
- in_cond_branch  in  1  conditional branch.
- in_uncond_branch  in  1  jump.
- in_tag  in  TAG_W  pass-through tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_result  out  XLEN  ALU result.
- out_take_branch  out  1  uncond OR (cond AND condition true).
- out_tag  out  TAG_W  tag of the op on out_result.
- occupancy  out  OCC_W  number of valid stages.

Behaviour:
- Accept condition: in_valid & in_ready & ~flush.
- Output transfer condition: out_valid & out_ready.
- Compute happens combinationally on the inputs. The result, take_branch and tag enter stage 0 at accept. Stage k moves to k+1 each non-stalled cycle. out_* comes from stage LATENCY-1 registers.
  - Accept at edge T gives out_valid during cycle T+LATENCY-1 after that edge (LATENCY=1: visible the cycle right after accept).
- Stall = valid[LATENCY-1] & ~out_ready. On stall, all stages hold and in_ready=0. Otherwise in_ready=1.
- Pipeline is global-stall, no bubble collapse. Bubbles advance like ops.
- ALU ops:
  - ADD, SUB, AND, OR, XOR, SLT (signed), SLTU.
  - SLL, SRL, SRA with shift amount opb[4:0].
  - MUL (low XLEN), MULH (s×s), MULHSU (s×u), MULHU (u×u).
  - Any other encoding gives result XLEN'hfacebeec.
- Branch conditions:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010/011 give cond=0.
  - take_branch = uncond | (cond_branch & cond).
- flush:
  - At the next edge, every stage valid is cleared and occupancy becomes 0.
  - Data registers are don't-care.
  - Any same-cycle input is dropped.
  - out_valid is gated combinationally: out_valid = valid[LATENCY-1] & ~flush, so no transfer occurs in the flush cycle.
  - in_ready during flush follows the stall rule, but nothing is accepted.
- occupancy = popcount of stage valids, registered alongside them.
  - Accept plus transfer in the same cycle leaves the count unchanged.
  - Never exceeds LATENCY.
- Reset (async, low):
  - All stage valids = 0.
  - out_valid=0, out_result=0, out_take_branch=0, out_tag=0, occupancy=0, in_ready=1.
- Reset mid-operation discards everything immediately.
- After reset deasserts, the first accept is allowed on the first clock edge.
- X on data inputs while in_valid=0 must not propagate into any valid bit.

Test Plan:
- LATENCY=2, accept ADD 5+7 tag 3 at cycle 0, out_ready=1 -> out_valid at cycle 2, result 12, tag 3. Back-to-back issues give one result per cycle.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. SRA 0x80000000 by 31 -> 0xFFFFFFFF. Bad func -> 0xfacebeec.
- BLT rs1=0xFFFFFFFF, rs2=1, cond_branch=1 -> take_branch=1. BLTU with the same operands -> 0. Jump with cond false -> take_branch=1.
- Fill pipeline, hold out_ready=0 for 4 cycles -> in_ready=0, occupancy=LATENCY, output held stable. Release -> results drain in order, no loss or duplication.
- Pipeline full, assert flush with in_valid=1 -> out_valid=0 that cycle, occupancy=0 next cycle, flushed tags never appear.
- Drive reset low asynchronously mid-stream between edges -> all outputs zero immediately. Release -> ADD 1+1 accepted at the first edge and emerges after LATENCY cycles; rerun with LATENCY=1 and LATENCY=4.
